// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: constants and types shared by the Core101 fetch stage.
// Build option: FETCH_PREFETCH_EN selects a two-entry instruction buffer
// so that a new request can issue while one entry is still buffered.
package fetch_unit_pkg;

   // Instruction shown when the buffer is empty (addi x0, x0, 0)
   localparam logic [31:0] NOP_INS = 32'h0000_0013;

   // Width of one instruction word
   localparam int INS_W = 32;

   // Byte distance between sequential fetches
   localparam int PC_INC = 4;

`ifdef FETCH_PREFETCH_EN
   localparam int FETCH_DEPTH = 2;
`else
   localparam int FETCH_DEPTH = 1;
`endif

   // Request-side state machine encoding
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_DROP = 2'd3
   } fetch_state_t;

   // A buffer entry is {pc, instruction}
   function automatic int entry_width(input int xlen);
      return xlen + INS_W;
   endfunction

endpackage

// File: rtl/fetch_unit_buffer.sv
// fetch_buffer: small wrap-around FIFO holding fetched {pc, ins} entries.
// Push, pop and flush are single-cycle; flush wins over push/pop. The head
// entry is presented combinationally from the entry registers.
module fetch_buffer #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 1
)(
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         push,
   input  logic [WIDTH-1:0]             push_data,
   input  logic                         pop,
   input  logic                         flush,
   output logic [WIDTH-1:0]             head,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         empty
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [PTR_W-1:0]            wr_ptr_reg;
   logic [PTR_W-1:0]            rd_ptr_reg;
   logic [CNT_W-1:0]            count_reg;
   logic [DEPTH-1:0][WIDTH-1:0] entry_data;
   logic                        full;
   logic                        do_push;
   logic                        do_pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign full  = (count_reg == CNT_W'(DEPTH));
   assign empty = (count_reg == '0);
   assign count = count_reg;

   // A push into a full buffer is only accepted when a pop frees a slot
   assign do_push = push & (~full | pop) & ~flush;
   assign do_pop  = pop & ~empty & ~flush;

   // Pointer and occupancy bookkeeping
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else if (flush) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push)
            wr_ptr_reg <= ptr_inc(wr_ptr_reg);
         if (do_pop)
            rd_ptr_reg <= ptr_inc(rd_ptr_reg);
         case ({do_push, do_pop})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
      end
   end

   // One register per slot, written when the write pointer selects it
   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
         logic [WIDTH-1:0] data_reg;

         // Capture pushed data into this slot
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
               data_reg <= '0;
            else if (do_push && (wr_ptr_reg == PTR_W'(gi)))
               data_reg <= push_data;
         end

         assign entry_data[gi] = data_reg;
      end

      if (DEPTH == 1) begin : g_head_single
         assign head = entry_data[0];
      end else begin : g_head_multi
         assign head = entry_data[rd_ptr_reg];
      end
   endgenerate

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: Core101 instruction-fetch stage. Owns the fetch PC, runs the
// instruction-memory req/gnt/rvalid handshake and buffers responses for the
// PC/IF register. Build option FETCH_PREFETCH_EN (see fetch_unit_pkg)
// enlarges the buffer to two entries so requests can overlap consumption.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter int              XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_VECTOR = '0
)(
   input  logic            fetch_clock_in,
   input  logic            fetch_reset_in,
   input  logic            fetch_ins_req_in,
   input  logic            fetch_pc_set_in,
   input  logic            fetch_redirect_in,
   input  logic [XLEN-1:0] fetch_redirect_addr_in,
   output logic            fetch_mem_req_out,
   output logic [XLEN-1:0] fetch_mem_addr_out,
   input  logic            fetch_mem_gnt_in,
   input  logic            fetch_mem_rvalid_in,
   input  logic [31:0]     fetch_mem_rdata_in,
   output logic            fetch_ins_ready_out,
   output logic [31:0]     fetch_ins_out,
   output logic [XLEN-1:0] fetch_pc_out
);

   localparam int              DEPTH      = FETCH_DEPTH;
   localparam int              ENTRY_W    = entry_width(XLEN);
   localparam int              CNT_W      = $clog2(DEPTH + 1);
   localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);
   localparam logic [XLEN-1:0] PC_STEP    = XLEN'(PC_INC);

   fetch_state_t     state_reg;
   fetch_state_t     state_next;
   logic [XLEN-1:0]  fetch_pc_reg;
   logic [XLEN-1:0]  fetch_pc_next;
   logic [XLEN-1:0]  req_pc_reg;
   logic [XLEN-1:0]  req_pc_next;
   logic             mem_req_reg;
   logic [XLEN-1:0]  mem_addr_reg;
   logic [XLEN-1:0]  last_pc_reg;

   logic             push;
   logic             pop;
   logic             flush;
   logic [ENTRY_W-1:0] buf_head;
   logic [CNT_W-1:0] buf_count;
   logic             buf_empty;
   logic [XLEN-1:0]  head_pc;
   logic [31:0]      head_ins;
   logic             room_now;
   logic             room_after_push;

   fetch_buffer #(
      .WIDTH (ENTRY_W),
      .DEPTH (DEPTH)
   ) u_buffer (
      .clk       (fetch_clock_in),
      .rst_n     (fetch_reset_in),
      .push      (push),
      .push_data ({req_pc_reg, fetch_mem_rdata_in}),
      .pop       (pop),
      .flush     (flush),
      .head      (buf_head),
      .count     (buf_count),
      .empty     (buf_empty)
   );

   assign head_pc  = buf_head[ENTRY_W-1:INS_W];
   assign head_ins = buf_head[INS_W-1:0];

   // Space checks: IDLE has nothing outstanding; in WAIT the returning word
   // occupies a slot, possibly freed by a pop in the same cycle.
   assign room_now        = (int'(buf_count) < DEPTH);
   assign room_after_push = ((int'(buf_count) + 1 - int'(pop)) < DEPTH);

   // State, fetch PC and request PC registers
   always_ff @(posedge fetch_clock_in or negedge fetch_reset_in) begin
      if (!fetch_reset_in) begin
         state_reg    <= ST_IDLE;
         fetch_pc_reg <= RESET_VECTOR;
         req_pc_reg   <= RESET_VECTOR;
      end else begin
         state_reg    <= state_next;
         fetch_pc_reg <= fetch_pc_next;
         req_pc_reg   <= req_pc_next;
      end
   end

   // Next-state logic; redirect overrides all normal transitions
   always_comb begin
      state_next    = state_reg;
      fetch_pc_next = fetch_pc_reg;
      req_pc_next   = req_pc_reg;
      if (fetch_redirect_in) begin
         fetch_pc_next = fetch_redirect_addr_in & ALIGN_MASK;
         case (state_reg)
            ST_IDLE: state_next = ST_IDLE;
            ST_REQ:  state_next = fetch_mem_gnt_in ? ST_DROP : ST_IDLE;
            ST_WAIT: state_next = fetch_mem_rvalid_in ? ST_IDLE : ST_DROP;
            // A response arriving with the redirect is the one being dropped;
            // waiting for another would hang the stage.
            ST_DROP: state_next = fetch_mem_rvalid_in ? ST_IDLE : ST_DROP;
            default: state_next = ST_IDLE;
         endcase
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (room_now)
                  state_next = ST_REQ;
            end
            ST_REQ: begin
               if (fetch_mem_gnt_in) begin
                  state_next    = ST_WAIT;
                  req_pc_next   = fetch_pc_reg;
                  fetch_pc_next = fetch_pc_reg + PC_STEP;
               end
            end
            ST_WAIT: begin
               if (fetch_mem_rvalid_in)
                  state_next = room_after_push ? ST_REQ : ST_IDLE;
            end
            ST_DROP: begin
               if (fetch_mem_rvalid_in)
                  state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
         endcase
      end
   end

   // Buffer control strobes derived from state and handshake inputs
   always_comb begin
      flush = fetch_redirect_in;
      pop   = fetch_ins_req_in & fetch_pc_set_in & ~buf_empty & ~fetch_redirect_in;
      push  = (state_reg == ST_WAIT) & fetch_mem_rvalid_in & ~fetch_redirect_in;
   end

   // Registered memory request; address follows the fetch PC, which only
   // moves on a grant or a redirect, so it is stable while req waits
   always_ff @(posedge fetch_clock_in or negedge fetch_reset_in) begin
      if (!fetch_reset_in) begin
         mem_req_reg  <= 1'b0;
         mem_addr_reg <= RESET_VECTOR;
      end else begin
         mem_req_reg  <= (state_next == ST_REQ);
         mem_addr_reg <= fetch_pc_next;
      end
   end

   // Remember the most recently presented PC for display while empty
   always_ff @(posedge fetch_clock_in or negedge fetch_reset_in) begin
      if (!fetch_reset_in)
         last_pc_reg <= RESET_VECTOR;
      else if (!buf_empty)
         last_pc_reg <= head_pc;
   end

   assign fetch_mem_req_out   = mem_req_reg;
   assign fetch_mem_addr_out  = mem_addr_reg;
   assign fetch_ins_ready_out = ~buf_empty;
   assign fetch_ins_out       = buf_empty ? NOP_INS : head_ins;
   assign fetch_pc_out        = buf_empty ? last_pc_reg : head_pc;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed self-checking bench for fetch_unit.
// Honours FETCH_PREFETCH_EN to pick the expected buffer depth.
`timescale 1ns/1ps
module tb_fetch_unit;

`ifdef FETCH_PREFETCH_EN
   localparam int DEPTH = 2;
`else
   localparam int DEPTH = 1;
`endif
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ins_req;
   logic        pc_set;
   logic        redirect;
   logic [31:0] redirect_addr;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        gnt;
   logic        rvalid;
   logic [31:0] rdata;
   logic        ins_ready;
   logic [31:0] ins;
   logic [31:0] pc;

   int          tests = 0;
   int          fails = 0;
   int          req_count = 0;
   logic [31:0] last_addr = '0;
   logic        gnt_auto = 1'b0;
   logic        resp_auto = 1'b0;

   fetch_unit #(
      .XLEN         (32),
      .RESET_VECTOR (32'h0000_0000)
   ) dut (
      .fetch_clock_in         (clk),
      .fetch_reset_in         (rst_n),
      .fetch_ins_req_in       (ins_req),
      .fetch_pc_set_in        (pc_set),
      .fetch_redirect_in      (redirect),
      .fetch_redirect_addr_in (redirect_addr),
      .fetch_mem_req_out      (mem_req),
      .fetch_mem_addr_out     (mem_addr),
      .fetch_mem_gnt_in       (gnt),
      .fetch_mem_rvalid_in    (rvalid),
      .fetch_mem_rdata_in     (rdata),
      .fetch_ins_ready_out    (ins_ready),
      .fetch_ins_out          (ins),
      .fetch_pc_out           (pc)
   );

   always #5 clk = ~clk;

   // Instruction word the memory model returns for an address
   function automatic logic [31:0] ins_for(input logic [31:0] a);
      return 32'h0050_0093 + (a << 8);
   endfunction

   // One clock: log/record an accepted request, then drive the memory model
   task automatic tick();
      logic        acc;
      logic [31:0] acc_addr;
      acc      = mem_req && gnt;
      acc_addr = mem_addr;
      if (acc) begin
         req_count++;
         last_addr = acc_addr;
         $display("[TB] t=%0t request accepted addr=%h", $time, acc_addr);
      end
      @(posedge clk);
      #1;
      if (resp_auto) begin
         rvalid = acc;
         rdata  = acc ? ins_for(acc_addr) : 32'h0;
      end
      if (gnt_auto)
         gnt = 1'b1;
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      ins_req = 0; pc_set = 0; redirect = 0; redirect_addr = '0;
      gnt = 0; rvalid = 0; rdata = '0;
      gnt_auto = 0; resp_auto = 0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      req_count = 0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      ins_req = 0; pc_set = 0; redirect = 0; redirect_addr = '0;
      gnt = 0; rvalid = 0; rdata = '0;
      repeat (2) @(posedge clk);
      #1;
      tests++; if (mem_req !== 1'b0) begin fails++; $display("FAIL reset_req: got %b want 0", mem_req); end
      tests++; if (mem_addr !== 32'h0) begin fails++; $display("FAIL reset_addr: got %h want 0", mem_addr); end
      tests++; if (ins_ready !== 1'b0) begin fails++; $display("FAIL reset_ready: got %b want 0", ins_ready); end
      tests++; if (ins !== NOP) begin fails++; $display("FAIL reset_ins: got %h want %h", ins, NOP); end
      tests++; if (pc !== 32'h0) begin fails++; $display("FAIL reset_pc: got %h want 0", pc); end
      $display("[TB] test_reset done");
   endtask

   task automatic test_basic();
      apply_reset();
      gnt_auto = 1; resp_auto = 1; gnt = 1;
      tick();  // IDLE -> REQ
      tests++; if (mem_req !== 1'b1) begin fails++; $display("FAIL basic_req_hi: got %b want 1", mem_req); end
      tests++; if (mem_addr !== 32'h0) begin fails++; $display("FAIL basic_addr0: got %h want 0", mem_addr); end
      tick();  // grant -> WAIT
      tests++; if (mem_addr !== 32'h4) begin fails++; $display("FAIL basic_addr4: got %h want 4", mem_addr); end
      tests++; if (ins_ready !== 1'b0) begin fails++; $display("FAIL basic_ready_early: got %b want 0", ins_ready); end
      tick();  // response pushed
      tests++; if (ins_ready !== 1'b1) begin fails++; $display("FAIL basic_ready: got %b want 1", ins_ready); end
      tests++; if (ins !== 32'h0050_0093) begin fails++; $display("FAIL basic_ins: got %h want 00500093", ins); end
      tests++; if (pc !== 32'h0) begin fails++; $display("FAIL basic_pc: got %h want 0", pc); end
      $display("[TB] test_basic done");
   endtask

   // Continues from test_basic with the controller idle
   task automatic test_prefetch_limit();
      logic [31:0] exp_last;
      logic [31:0] exp_ins;
      logic [31:0] exp_pc;
      logic        exp_ready;
      exp_last  = (DEPTH == 2) ? 32'h4 : 32'h0;
      exp_ready = (DEPTH == 2);
      exp_ins   = (DEPTH == 2) ? ins_for(32'h4) : NOP;
      exp_pc    = (DEPTH == 2) ? 32'h4 : 32'h0;
      repeat (8) tick();
      tests++; if (req_count !== DEPTH) begin fails++; $display("FAIL limit_count: got %0d want %0d", req_count, DEPTH); end
      tests++; if (last_addr !== exp_last) begin fails++; $display("FAIL limit_last_addr: got %h want %h", last_addr, exp_last); end
      tests++; if (mem_req !== 1'b0) begin fails++; $display("FAIL limit_req_low: got %b want 0", mem_req); end
      tests++; if (pc !== 32'h0) begin fails++; $display("FAIL limit_head_pc: got %h want 0", pc); end
      ins_req = 1; pc_set = 1;
      tick();
      ins_req = 0; pc_set = 0;
      tests++; if (ins_ready !== exp_ready) begin fails++; $display("FAIL limit_pop_ready: got %b want %b", ins_ready, exp_ready); end
      tests++; if (ins !== exp_ins) begin fails++; $display("FAIL limit_pop_ins: got %h want %h", ins, exp_ins); end
      tests++; if (pc !== exp_pc) begin fails++; $display("FAIL limit_pop_pc: got %h want %h", pc, exp_pc); end
      $display("[TB] test_prefetch_limit done");
   endtask

   task automatic test_gnt_hold();
      apply_reset();
      resp_auto = 1; gnt = 0;
      tick();  // IDLE -> REQ
      for (int i = 0; i < 5; i++) begin
         tick();
         tests++;
         if ({mem_req, mem_addr} !== {1'b1, 32'h0}) begin
            fails++;
            $display("FAIL hold_cycle%0d: req=%b addr=%h want req=1 addr=0", i, mem_req, mem_addr);
         end
      end
      gnt = 1;
      tick();
      gnt = 0;
      tests++; if (mem_req !== 1'b0) begin fails++; $display("FAIL hold_req_drop: got %b want 0", mem_req); end
      tests++; if (req_count !== 1) begin fails++; $display("FAIL hold_req_count: got %0d want 1", req_count); end
      tick();
      tests++; if (ins_ready !== 1'b1) begin fails++; $display("FAIL hold_ready: got %b want 1", ins_ready); end
      tests++; if (ins !== ins_for(32'h0)) begin fails++; $display("FAIL hold_ins: got %h want %h", ins, ins_for(32'h0)); end
      $display("[TB] test_gnt_hold done");
   endtask

   task automatic test_redirect();
      apply_reset();
      gnt_auto = 1; gnt = 1;
      tick();  // REQ
      tick();  // granted, WAIT
      redirect = 1; redirect_addr = 32'h0000_0102;
      tick();  // WAIT without rvalid -> DROP
      redirect = 0;
      tests++; if (ins_ready !== 1'b0) begin fails++; $display("FAIL redir_ready: got %b want 0", ins_ready); end
      tests++; if (mem_req !== 1'b0) begin fails++; $display("FAIL redir_req_low: got %b want 0", mem_req); end
      rvalid = 1; rdata = 32'hDEAD_BEEF; resp_auto = 1;
      tick();  // stale response dropped
      tests++; if (ins_ready !== 1'b0) begin fails++; $display("FAIL redir_drop: got %b want 0", ins_ready); end
      tick();  // IDLE -> REQ at new target
      tests++; if (mem_req !== 1'b1) begin fails++; $display("FAIL redir_new_req: got %b want 1", mem_req); end
      tests++; if (mem_addr !== 32'h100) begin fails++; $display("FAIL redir_addr: got %h want 00000100", mem_addr); end
      tick();
      tick();
      tests++; if (pc !== 32'h100) begin fails++; $display("FAIL redir_pc: got %h want 00000100", pc); end
      tests++; if (ins !== ins_for(32'h100)) begin fails++; $display("FAIL redir_ins: got %h want %h", ins, ins_for(32'h100)); end
      $display("[TB] test_redirect done");
   endtask

   task automatic test_pop_push();
      apply_reset();
      gnt_auto = 1; resp_auto = 1; gnt = 1;
`ifdef FETCH_PREFETCH_EN
      tick(); tick(); tick();  // first word buffered, second request up
      tick();                  // second request granted
      ins_req = 1; pc_set = 1;
      tick();                  // pop head and push second word together
      ins_req = 0; pc_set = 0;
      tests++; if (ins_ready !== 1'b1) begin fails++; $display("FAIL pp_ready: got %b want 1", ins_ready); end
      tests++; if (ins !== ins_for(32'h4)) begin fails++; $display("FAIL pp_ins: got %h want %h", ins, ins_for(32'h4)); end
      tests++; if (pc !== 32'h4) begin fails++; $display("FAIL pp_pc: got %h want 4", pc); end
      tick(); tick();          // third word fills buffer
      ins_req = 1; pc_set = 1;
      tick();
      tests++; if (pc !== 32'h8) begin fails++; $display("FAIL pp_next_pc: got %h want 8", pc); end
      tests++; if (ins !== ins_for(32'h8)) begin fails++; $display("FAIL pp_next_ins: got %h want %h", ins, ins_for(32'h8)); end
      tick();
      ins_req = 0; pc_set = 0;
      tests++; if (ins_ready !== 1'b0) begin fails++; $display("FAIL pp_empty: got %b want 0", ins_ready); end
      tests++; if (ins !== NOP) begin fails++; $display("FAIL pp_empty_ins: got %h want %h", ins, NOP); end
`else
      tick(); tick(); tick();  // one word buffered, stage idle
      ins_req = 1; pc_set = 1;
      tick();
      ins_req = 0; pc_set = 0;
      tests++; if (ins_ready !== 1'b0) begin fails++; $display("FAIL pp_empty: got %b want 0", ins_ready); end
      tests++; if (ins !== NOP) begin fails++; $display("FAIL pp_empty_ins: got %h want %h", ins, NOP); end
      tests++; if (pc !== 32'h0) begin fails++; $display("FAIL pp_last_pc: got %h want 0", pc); end
      tick();
      tests++; if (mem_req !== 1'b1) begin fails++; $display("FAIL pp_req: got %b want 1", mem_req); end
      tests++; if (mem_addr !== 32'h4) begin fails++; $display("FAIL pp_addr: got %h want 4", mem_addr); end
      tick(); tick();
      tests++; if (pc !== 32'h4) begin fails++; $display("FAIL pp_pc: got %h want 4", pc); end
      tests++; if (ins !== ins_for(32'h4)) begin fails++; $display("FAIL pp_ins: got %h want %h", ins, ins_for(32'h4)); end
`endif
      $display("[TB] test_pop_push done");
   endtask

   task automatic test_reset_mid();
      apply_reset();
      gnt_auto = 1; gnt = 1;
      tick();  // REQ
      tick();  // granted, WAIT, addr now 4
      rst_n = 1'b0;
      #1;
      tests++; if (mem_req !== 1'b0) begin fails++; $display("FAIL rmid_req: got %b want 0", mem_req); end
      tests++; if (mem_addr !== 32'h0) begin fails++; $display("FAIL rmid_addr: got %h want 0", mem_addr); end
      gnt_auto = 0; gnt = 0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      rvalid = 1; rdata = 32'hDEAD_BEEF;
      tick();  // stale response while IDLE
      rvalid = 0;
      tests++; if (ins_ready !== 1'b0) begin fails++; $display("FAIL rmid_ignore: got %b want 0", ins_ready); end
      tests++; if (mem_req !== 1'b1) begin fails++; $display("FAIL rmid_new_req: got %b want 1", mem_req); end
      tests++; if (mem_addr !== 32'h0) begin fails++; $display("FAIL rmid_new_addr: got %h want 0", mem_addr); end
      gnt = 1; gnt_auto = 1; resp_auto = 1;
      tick();
      tick();
      tests++; if (pc !== 32'h0) begin fails++; $display("FAIL rmid_pc: got %h want 0", pc); end
      tests++; if (ins !== ins_for(32'h0)) begin fails++; $display("FAIL rmid_ins: got %h want %h", ins, ins_for(32'h0)); end
      $display("[TB] test_reset_mid done");
   endtask

   initial begin
      test_reset();
      test_basic();
      test_prefetch_limit();
      test_gnt_hold();
      test_redirect();
      test_pop_push();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

endmodule
